// File: rtl/ahb_req_arbiter_pkg.sv
// Shared types for the AHB request arbiter: transfer encodings, response codes, FSM states.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_t;

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// AHB-lite bus between the arbiter (master) and Bridge_Top (slave).
interface ahb_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] Haddr;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyin;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;

  modport master (
    output Haddr, Htrans, Hwrite, Hwdata, Hreadyin,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Haddr, Htrans, Hwrite, Hwdata, Hreadyin,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_req_arbiter_rr_picker.sv
// Rotating-priority search: first set request bit after the last winner, with wrap.
module rr_picker #(
  parameter  int NUM_REQ = 3,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               any_o,
  output logic [IW-1:0]      win_o
);

  // Scan farthest-to-nearest so the nearest requester after last_i overwrites the rest.
  always_comb begin
    int idx;
    idx   = 0;
    any_o = 1'b0;
    win_o = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        any_o = 1'b1;
        win_o = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing one AHB-lite slave port between NUM_REQ requesters.
// Each grant becomes one NONSEQ single transfer (address phase, then data phase).
// Optional wait-state watchdog: define AHB_ARB_TIMEOUT_EN.
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 3,
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [IW-1:0]             grant_id,
  ahb_req_arbiter_if.master         bus
);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       last_q, last_d, grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  htrans_t             htrans;
  logic                any;
  logic [IW-1:0]       win;

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .any_o  (any),
    .win_o  (win)
  );

  // Next-state, grant capture and response generation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    htrans      = IDLE;
`ifdef AHB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          req_ready[win] = 1'b1;
          grant_d        = win;
          last_d         = win;
          addr_d         = req_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d        = req_wdata[int'(win)*DATA_W +: DATA_W];
          write_d        = req_write[win];
          state_d        = ST_ADDR;
`ifdef AHB_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      ST_ADDR, ST_DATA: begin
        if (state_q == ST_ADDR) htrans = NONSEQ;
        if (bus.Hreadyout) begin
          if (state_q == ST_ADDR) begin
            state_d = ST_DATA;
          end else begin
            state_d              = ST_IDLE;
            rsp_valid_d[grant_q] = 1'b1;
            rsp_err_d            = (bus.Hresp != HRESP_OKAY);
            rsp_rdata_d          = (!write_q && bus.Hresp == HRESP_OKAY) ? bus.Hrdata : '0;
          end
        end else begin
`ifdef AHB_ARB_TIMEOUT_EN
          // The last permitted stall abandons the transfer with an error response.
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d              = ST_IDLE;
            rsp_valid_d[grant_q] = 1'b1;
            rsp_err_d            = 1'b1;
            rsp_rdata_d          = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; synchronous reset aborts any transfer in flight.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      grant_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef AHB_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.Htrans   = htrans;
  assign bus.Haddr    = addr_q;
  assign bus.Hwrite   = write_q;
  assign bus.Hwdata   = (state_q == ST_DATA && write_q) ? wdata_q : '0;
  assign bus.Hreadyin = bus.Hreadyout;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Bench for ahb_req_arbiter: directed scenarios plus randomized transfers,
// compared against a transaction-level model of grant order and responses.
module tb_ahb_req_arbiter;
  localparam int N = 3, AW = 32, DW = 32;

  logic          Hclk = 1'b0;
  logic          Hreset = 1'b1;
  logic [N-1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [1:0]    grant_id;

  ahb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  ahb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant_id(grant_id), .bus(bus)
  );

  always #5 Hclk = ~Hclk;

  int checks = 0, errors = 0;

  // Reference model state: last grant, one outstanding response, held response values.
  int          ml;
  bit          pend;
  int          pg;
  logic [DW-1:0] prd, hold_rd;
  logic        perr, hold_err;

  task automatic tick();
    @(posedge Hclk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] reqv);
    for (int k = 1; k <= N; k++)
      if (reqv[(ml + k) % N]) return (ml + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    ml = N - 1; pend = 0; hold_rd = '0; hold_err = 1'b0;
  endtask

  task automatic apply_reset();
    Hreset = 1'b1; req_valid = '0; bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
    tick(); tick(); #1;
    chk("rst_htrans", bus.Htrans, 0);
    chk("rst_haddr", bus.Haddr, 0);
    chk("rst_hwdata", bus.Hwdata, 0);
    chk("rst_hwrite", bus.Hwrite, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_grant_id", grant_id, 0);
    Hreset = 1'b0;
    model_reset();
  endtask

  // Called in an IDLE cycle: either the pending response shows now, or the old one holds.
  task automatic check_idle_rsp();
    if (pend) begin
      chk("rsp_valid", rsp_valid, 64'(1) << pg);
      chk("rsp_err", rsp_err, perr);
      chk("rsp_rdata", rsp_rdata, prd);
      hold_rd = prd; hold_err = perr; pend = 0;
    end else begin
      chk("rsp_valid_quiet", rsp_valid, 0);
      chk("rsp_rdata_hold", rsp_rdata, hold_rd);
      chk("rsp_err_hold", rsp_err, hold_err);
    end
  endtask

  task automatic flush();
    tick(); req_valid = '0; #1;
    check_idle_rsp();
    chk("flush_req_ready", req_ready, 0);
  endtask

  // One transfer: accept cycle, wa address wait states, wd data wait states.
  task automatic do_xfer(input logic [N-1:0] reqv, input int wa, input int wd,
                         input logic [1:0] resp, input logic [DW-1:0] rdata, output int og);
    int g; logic [AW-1:0] ea; logic [DW-1:0] ed; logic ew;
    tick(); req_valid = reqv; bus.Hreadyout = 1'b1; bus.Hresp = 2'b00; #1;
    check_idle_rsp();
    g  = pick(reqv);
    chk("req_ready", req_ready, 64'(1) << g);
    chk("htrans_idle", bus.Htrans, 0);
    ea = req_addr[g*AW +: AW]; ed = req_wdata[g*DW +: DW]; ew = req_write[g];
    ml = g; og = -1;
    for (int i = 0; i <= wa; i++) begin
      tick();
      req_valid = '0;
      req_addr  = {$urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom};
      req_write = N'($urandom);
      bus.Hreadyout = (i == wa);
      #1;
      if (i == 0) og = int'(grant_id);
      chk("htrans_addr", bus.Htrans, 2);
      chk("haddr", bus.Haddr, ea);
      chk("hwrite", bus.Hwrite, ew);
      chk("grant_id", grant_id, g);
      chk("addr_rsp_valid", rsp_valid, 0);
      chk("addr_req_ready", req_ready, 0);
      chk("hreadyin", bus.Hreadyin, bus.Hreadyout);
    end
    for (int i = 0; i <= wd; i++) begin
      tick();
      bus.Hreadyout = (i == wd);
      bus.Hresp     = (i == wd) ? resp : 2'b00;
      bus.Hrdata    = (i == wd) ? rdata : $urandom;
      #1;
      chk("htrans_data", bus.Htrans, 0);
      chk("hwdata", bus.Hwdata, ew ? ed : '0);
      chk("data_rsp_valid", rsp_valid, 0);
    end
    pend = 1; pg = g; perr = (resp != 2'b00);
    prd  = (!ew && resp == 2'b00) ? rdata : '0;
  endtask

  initial begin
    int og;
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    bus.Hreadyout = 1'b1; bus.Hresp = 2'b00; bus.Hrdata = '0;
    model_reset();
    apply_reset();

    // Single write from requester 0, then a back-to-back read from requester 1.
    req_addr[0 +: AW] = 32'h8000_0004; req_wdata[0 +: DW] = 32'hA5A5_5A5A; req_write = 3'b001;
    do_xfer(3'b001, 0, 0, 2'b00, 32'hDEAD_BEEF, og);
    chk("write_grant", og, 0);
    req_addr[AW +: AW] = 32'h8000_0100; req_write = 3'b000;
    do_xfer(3'b010, 0, 0, 2'b00, 32'h1234_5678, og);
    chk("read_grant", og, 1);
    flush();

    // Persistent requesters: grant order rotates from a fresh reset.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req_write = 3'b101;
      do_xfer(3'b111, 0, 0, 2'b00, $urandom, og);
      chk("rr_order", og, exp_order[i]);
    end
    flush();

    // Four data-phase wait states on a write; Hwdata held throughout.
    req_addr[0 +: AW] = 32'h8000_0040; req_wdata[0 +: DW] = 32'h0BAD_F00D; req_write = 3'b001;
    do_xfer(3'b001, 0, 4, 2'b00, $urandom, og);
    // Read that completes with an error response.
    req_addr[2*AW +: AW] = 32'h8000_0200; req_write = 3'b000;
    do_xfer(3'b100, 1, 0, 2'b01, 32'hFFFF_0000, og);
    flush();

    // Randomized transfers with random requests, wait states and responses.
    for (int t = 0; t < 30; t++) begin
      req_addr  = {$urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom};
      req_write = N'($urandom);
      do_xfer(N'($urandom_range(1, 7)), $urandom_range(0, 2), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, $urandom, og);
    end
    flush();

    // Reset during the data phase: transfer dropped, no response.
    tick(); req_valid = 3'b100; req_write = 3'b100; #1;
    chk("mid_req_ready", req_ready, 64'(1) << pick(3'b100));
    tick(); req_valid = '0; bus.Hreadyout = 1'b1; #1;
    tick(); bus.Hreadyout = 1'b0; #1;
    chk("mid_htrans_data", bus.Htrans, 0);
    Hreset = 1'b1;
    tick(); #1;
    chk("mid_rst_htrans", bus.Htrans, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_hwdata", bus.Hwdata, 0);
    Hreset = 1'b0; bus.Hreadyout = 1'b1; model_reset();
    tick(); #1;
    chk("mid_post_rsp_valid", rsp_valid, 0);
    chk("mid_post_rsp_err", rsp_err, 0);

`ifdef AHB_ARB_TIMEOUT_EN
    begin
      int n; bit found;
      n = 0; found = 0;
      tick(); req_valid = 3'b001; req_write = 3'b000; #1;
      chk("to_req_ready", req_ready, 64'(1) << pick(3'b001));
      ml = pick(3'b001);
      repeat (200) begin
        tick(); req_valid = '0; bus.Hreadyout = 1'b0; #1;
        n++;
        if (rsp_valid != 0) begin found = 1; break; end
      end
      chk("to_found", found, 1);
      chk("to_latency_in_range", (n >= 64 && n <= 66), 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      bus.Hreadyout = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
